// File: rtl/g2b_pkg.sv
// ----------------------------------------------------------------------------
// g2b_pkg -- shared definitions for the g2b stream ALU.
//
// Contents:
//   mode_e          : per-beat operation codes (PASS..CLAMP)
//   acc_t           : wide signed intermediate used for lane arithmetic
//   is_defined_mode : true for codes PASS..CLAMP
//   sat_word        : clamps a wide signed value to a w-bit signed range
//
// Optional feature macro used by the lane: G2B_ALU_SAT_EN (saturating
// ADD/MUL/SCALE_SHIFT results instead of two's-complement wrap).
// ----------------------------------------------------------------------------
package g2b_pkg;

    typedef enum logic [7:0] {
        MODE_PASS  = 8'h00,
        MODE_ADD   = 8'h01,
        MODE_MUL   = 8'h02,
        MODE_RELU  = 8'h03,
        MODE_SCALE = 8'h04,
        MODE_CLAMP = 8'h05
    } mode_e;

    // Wide enough for a 2*WORD_WIDTH product plus offset for lanes up to 64 bits.
    localparam int unsigned ACC_W = 136;
    typedef logic signed [ACC_W-1:0] acc_t;

    function automatic logic is_defined_mode(input logic [7:0] mode);
        return mode <= 8'(MODE_CLAMP);
    endfunction

    function automatic acc_t sat_word(input acc_t v, input int unsigned w);
        acc_t hi;
        acc_t lo;
        hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
        lo = -(acc_t'(1) <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/g2b_alu_lane.sv
// ----------------------------------------------------------------------------
// g2b_alu_lane -- combinational second-stage math for one signed lane.
//
// Ports:
//   mode  : operation code travelling with the beat
//   x     : lane operand (signed WORD_WIDTH)
//   param : beat parameter (signed WORD_WIDTH)
//   prod  : x times the mode-selected multiplier, formed in the first stage
//   y     : lane result (signed WORD_WIDTH)
//
// Macro G2B_ALU_SAT_EN: when defined, ADD/MUL/SCALE_SHIFT saturate to the
// lane range; otherwise they keep the low WORD_WIDTH bits.
// ----------------------------------------------------------------------------
module g2b_alu_lane
    import g2b_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic        [7:0]              mode,
    input  logic signed [WORD_WIDTH-1:0]   x,
    input  logic signed [WORD_WIDTH-1:0]   param,
    input  logic signed [2*WORD_WIDTH-1:0] prod,
    output logic signed [WORD_WIDTH-1:0]   y
);

    localparam int W    = WORD_WIDTH;
    localparam int HALF = WORD_WIDTH / 2;

    function automatic logic signed [W-1:0] reduce(input acc_t v);
        acc_t s;
`ifdef G2B_ALU_SAT_EN
        s = sat_word(v, W);
`else
        s = v;
`endif
        return s[W-1:0];
    endfunction

    acc_t               sum_full;
    acc_t               prod_full;
    acc_t               scale_full;
    logic signed [W:0]  p_ext;
    logic signed [W:0]  abs_p;
    logic signed [W:0]  x_ext;
    logic signed [W:0]  clamp_v;

    always_comb begin
        sum_full   = acc_t'(x) + acc_t'(param);
        prod_full  = acc_t'(prod);
        // Low half of param is an unsigned offset added after the fixed-point shift.
        scale_full = (prod_full >>> FRAC_BITS) + acc_t'({1'b0, param[HALF-1:0]});

        // One extra bit so |most-negative param| is representable.
        p_ext   = {param[W-1], param};
        abs_p   = p_ext[W] ? -p_ext : p_ext;
        x_ext   = {x[W-1], x};
        clamp_v = x_ext;
        if (clamp_v < -abs_p) clamp_v = -abs_p;
        if (clamp_v > abs_p)  clamp_v = abs_p;

        y = x;
        case (mode)
            MODE_ADD:   y = reduce(sum_full);
            MODE_MUL:   y = reduce(prod_full);
            MODE_RELU:  y = x[W-1] ? '0 : x;
            MODE_SCALE: y = reduce(scale_full);
            MODE_CLAMP: y = clamp_v[W-1:0];
            default:    y = x;
        endcase
    end

endmodule

// File: rtl/g2b_stream_alu.sv
// ----------------------------------------------------------------------------
// g2b_stream_alu -- two-stage valid/ready streaming ALU over NUM_WORDS signed
// lanes. Each beat carries its own mode and parameter.
//
// Ports:
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_mode, i_param      : operation and parameter, captured with the beat
//   i_clear              : clears o_beat_count and o_mode_err
//   i_data, i_valid      : input beat and its valid
//   o_ready              : upstream may present a beat this cycle
//   o_data, o_valid      : processed beat and its valid
//   i_ready              : downstream accepts o_data this cycle
//   o_beat_count         : completed output handshakes (wraps)
//   o_mode_err           : sticky, an undefined mode was accepted
//
// Macro G2B_ALU_SAT_EN (see g2b_alu_lane): saturating ADD/MUL/SCALE_SHIFT.
// ----------------------------------------------------------------------------
module g2b_stream_alu
    import g2b_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int WORD_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [7:0]            i_mode,
    input  logic [WORD_WIDTH-1:0] i_param,
    input  logic                  i_clear,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [31:0]           o_beat_count,
    output logic                  o_mode_err
);

    localparam int NUM_WORDS = DATA_WIDTH / WORD_WIDTH;
    localparam int HALF      = WORD_WIDTH / 2;

    logic                         vld_p1;
    logic                         vld_p2;
    logic                         adv_p1;
    logic                         adv_p2;
    logic                         accept;
    logic [DATA_WIDTH-1:0]        data_p1;
    logic [7:0]                   mode_p1;
    logic signed [WORD_WIDTH-1:0] param_p1;
    logic signed [WORD_WIDTH:0]   mul_op;
    logic [DATA_WIDTH-1:0]        lane_y;
    logic [DATA_WIDTH-1:0]        data_p2;
    logic [31:0]                  beat_count;
    logic                         mode_err;

    assign adv_p2  = !vld_p2 || i_ready;
    assign adv_p1  = !vld_p1 || adv_p2;
    assign o_ready = i_reset || adv_p1;
    assign accept  = i_valid && adv_p1;

    // ---- Stage 1: capture beat, mode and param ----
    always_ff @(posedge i_clk) begin
        if (accept) begin
            data_p1  <= i_data;
            mode_p1  <= i_mode;
            param_p1 <= i_param;
        end
    end

    // SCALE_SHIFT multiplies by the upper half of param taken as unsigned.
    always_comb begin
        if (mode_p1 == MODE_SCALE)
            mul_op = {{(HALF + 1){1'b0}}, param_p1[WORD_WIDTH-1:HALF]};
        else
            mul_op = {param_p1[WORD_WIDTH-1], param_p1};
    end

    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_lane
        logic signed [WORD_WIDTH-1:0]   x;
        logic signed [2*WORD_WIDTH-1:0] prod;
        logic signed [WORD_WIDTH-1:0]   y;

        assign x    = data_p1[k*WORD_WIDTH +: WORD_WIDTH];
        assign prod = (2*WORD_WIDTH)'(x) * (2*WORD_WIDTH)'(mul_op);

        g2b_alu_lane #(
            .WORD_WIDTH (WORD_WIDTH),
            .FRAC_BITS  (FRAC_BITS)
        ) u_lane (
            .mode  (mode_p1),
            .x     (x),
            .param (param_p1),
            .prod  (prod),
            .y     (y)
        );

        assign lane_y[k*WORD_WIDTH +: WORD_WIDTH] = y;
    end

    // ---- Stage 2: register lane results ----
    always_ff @(posedge i_clk) begin
        if (i_reset)
            data_p2 <= '0;
        else if (adv_p2 && vld_p1)
            data_p2 <= lane_y;
    end

    // ---- Pipeline control and status ----
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            beat_count <= '0;
            mode_err   <= 1'b0;
        end else begin
            if (adv_p1) vld_p1 <= i_valid;
            if (adv_p2) vld_p2 <= vld_p1;

            if (i_clear)
                beat_count <= '0;
            else if (vld_p2 && i_ready)
                beat_count <= beat_count + 32'd1;

            // A bad-mode capture outranks a simultaneous clear.
            if (accept && !is_defined_mode(i_mode))
                mode_err <= 1'b1;
            else if (i_clear)
                mode_err <= 1'b0;
        end
    end

    assign o_data       = data_p2;
    assign o_valid      = vld_p2;
    assign o_beat_count = beat_count;
    assign o_mode_err   = mode_err;

endmodule

// File: tb/tb_g2b_stream_alu.sv
`timescale 1ns/1ps
module tb_g2b_stream_alu;

    localparam int DW = 256;
    localparam int WW = 32;
    localparam int NW = DW / WW;
    localparam int FB = 16;

    logic          clk = 1'b0;
    logic          i_reset, i_clear, i_valid, i_ready;
    logic [7:0]    i_mode;
    logic [WW-1:0] i_param;
    logic [DW-1:0] i_data;
    logic [DW-1:0] o_data;
    logic          o_valid, o_ready, o_mode_err;
    logic [31:0]   o_beat_count;

    always #5 clk = ~clk;

    g2b_stream_alu #(.DATA_WIDTH(DW), .WORD_WIDTH(WW), .FRAC_BITS(FB)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_mode(i_mode), .i_param(i_param),
        .i_clear(i_clear), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
        .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_beat_count(o_beat_count), .o_mode_err(o_mode_err)
    );

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] exp_q[$];
    logic [31:0]   out_l0[$];
    int            out_cyc[$];
    int            cyc = 0;
    int            inflight = 0;
    int            n_out = 0;
    int            rdy_mode = 0;
    int            pidx = 0;
    logic          hold_valid = 1'b0;
    logic [DW-1:0] hold_data;
    logic          exp_err;
    logic [DW-1:0] d;
    logic [DW-1:0] e;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] red(input longint v);
`ifdef G2B_ALU_SAT_EN
        if (v > 64'sd2147483647)  return 32'h7FFFFFFF;
        if (v < -64'sd2147483648) return 32'h80000000;
`endif
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_lane(input logic [7:0] m, input logic [31:0] p, input logic [31:0] x);
        longint lx, lp, a, c;
        lx = $signed(x);
        lp = $signed(p);
        case (m)
            8'h00: return x;
            8'h01: return red(lx + lp);
            8'h02: return red(lx * lp);
            8'h03: return (lx < 0) ? 32'h0 : x;
            8'h04: return red(((lx * longint'(p[31:16])) >>> FB) + longint'(p[15:0]));
            8'h05: begin
                a = (lp < 0) ? -lp : lp;
                c = lx;
                if (c < -a) c = -a;
                if (c > a)  c = a;
                return c[31:0];
            end
            default: return x;
        endcase
    endfunction

    function automatic logic [DW-1:0] model_beat(input logic [7:0] m, input logic [31:0] p, input logic [DW-1:0] din);
        logic [DW-1:0] r;
        for (int k = 0; k < NW; k++) r[k*WW +: WW] = model_lane(m, p, din[k*WW +: WW]);
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom();
        endcase
    endfunction

    // ---------------- downstream ready generator ----------------
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: i_ready = 1'b1;
                1: begin i_ready = !(pidx == 1 || pidx == 2); pidx = (pidx + 1) % 4; end
                2: i_ready = ($urandom_range(0, 3) != 0);
                default: i_ready = 1'b0;
            endcase
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (i_reset) begin
            inflight   = 0;
            n_out      = 0;
            hold_valid = 1'b0;
        end else begin
            check("ready_rule", o_ready, !(inflight == 2 && !i_ready));
            if (hold_valid) begin
                check("stall_valid", o_valid, 1'b1);
                check("stall_hold", o_data, hold_data);
            end
            hold_valid = 1'b0;
            if (o_valid) begin
                if (i_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_beat: actual %0h required none", o_data);
                    end else begin
                        check("beat_data", o_data, exp_q.pop_front());
                    end
                    out_l0.push_back(o_data[31:0]);
                    out_cyc.push_back(cyc);
                end else begin
                    hold_valid = 1'b1;
                    hold_data  = o_data;
                end
            end
            inflight = inflight + ((i_valid && o_ready) ? 1 : 0) - ((o_valid && i_ready) ? 1 : 0);
            if (i_clear) n_out = 0;
            else if (o_valid && i_ready) n_out++;
        end
    end

    // ---------------- driver helpers (all called at posedge+1) ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] m, input logic [31:0] p, input logic [DW-1:0] din);
        int  guard;
        logic ok;
        guard = 0;
        ok = 1'b0;
        i_valid = 1'b1; i_mode = m; i_param = p; i_data = din;
        while (!ok && guard < 200) begin
            @(negedge clk);
            if (o_ready) ok = 1'b1;
            else guard++;
        end
        if (ok) begin
            exp_q.push_back(model_beat(m, p, din));
            if (m > 8'h05) exp_err = 1'b1;
        end else begin
            tests++; fails++;
            $display("FAIL send_timeout: actual o_ready 0 required 1");
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 1000) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [DW-1:0] splat(input logic [31:0] v);
        logic [DW-1:0] r;
        for (int k = 0; k < NW; k++) r[k*WW +: WW] = v;
        return r;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        i_reset = 1'b1; i_clear = 1'b0; i_valid = 1'b0;
        i_mode = '0; i_param = '0; i_data = '0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", o_ready, 1'b1);
        check("rst_valid", o_valid, 1'b0);
        check("rst_data", o_data, '0);
        check("rst_count", o_beat_count, 0);
        check("rst_err", o_mode_err, 1'b0);
        step();
        i_reset = 1'b0;

        // ADD 10+5 with latency check
        send(8'h01, 32'd5, splat(32'd10));
        @(negedge clk);
        check("add_lat1_valid", o_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        check("add_lat2_valid", o_valid, 1'b1);
        check("add_data", o_data, splat(32'd15));
        step();
        @(negedge clk);
        check("add_count", o_beat_count, 1);
        step();

        // overflow
        d = '0; d[31:0] = 32'h7FFFFFFF;
        send(8'h01, 32'd1, d);
        @(posedge clk); @(negedge clk);
`ifdef G2B_ALU_SAT_EN
        check("ovf_lane0", o_data[31:0], 32'h7FFFFFFF);
`else
        check("ovf_lane0", o_data[31:0], 32'h80000000);
`endif
        step();
        drain();

        // per-beat mode change, back to back
        out_l0.delete(); out_cyc.delete();
        send(8'h02, 32'hFFFFFFFD, splat(32'd4));
        send(8'h03, 32'd0, splat(32'hFFFFFFF9));
        send(8'h04, 32'h00020001, splat(32'h00010000));
        drain();
        check("pb_count", out_l0.size(), 3);
        if (out_l0.size() == 3) begin
            check("pb_mul", out_l0[0], 32'hFFFFFFF4);
            check("pb_relu", out_l0[1], 32'h0);
            check("pb_scale", out_l0[2], 32'h3);
            check("pb_gap01", out_cyc[1] - out_cyc[0], 1);
            check("pb_gap12", out_cyc[2] - out_cyc[1], 1);
        end

        // stall pattern 1,0,0,1
        step();
        rdy_mode = 1; pidx = 0;
        out_l0.delete(); out_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < NW; k++) d[k*WW +: WW] = pick();
            send(8'($urandom_range(0, 5)), pick(), d);
        end
        drain();
        check("stall_count", out_l0.size(), 6);
        rdy_mode = 0;
        step();

        // bad mode then clear with a handshake
        for (int k = 0; k < NW; k++) d[k*WW +: WW] = $urandom();
        send(8'h7E, $urandom(), d);
        @(negedge clk);
        check("bad_err_set", o_mode_err, 1'b1);
        step();
        send(8'h00, 32'd0, d);
        @(posedge clk); #1;
        i_clear = 1'b1;
        @(negedge clk);
        check("clr_hs_present", o_valid && i_ready, 1'b1);
        step();
        i_clear = 1'b0;
        @(negedge clk);
        check("clr_count", o_beat_count, 0);
        check("clr_err", o_mode_err, 1'b0);
        step();

        // clear and bad-mode capture together
        i_clear = 1'b1;
        send(8'h9A, 32'd0, d);
        i_clear = 1'b0;
        @(negedge clk);
        check("clr_bad_setwins", o_mode_err, 1'b1);
        step();
        drain();

        // reset with two beats in flight
        rdy_mode = 3;
        step(); step();
        out_l0.delete(); out_cyc.delete();
        send(8'h01, 32'd1, splat(32'd100));
        send(8'h01, 32'd2, splat(32'd200));
        i_reset = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", o_ready, 1'b1);
        step();
        exp_q.delete();
        i_reset = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", o_valid, 1'b0);
        check("rst_mid_data", o_data, '0);
        check("rst_mid_count", o_beat_count, 0);
        rdy_mode = 0;
        repeat (6) step();
        check("rst_flushed", out_l0.size(), 0);
        send(8'h00, 32'd0, splat(32'd77));
        @(negedge clk);
        check("post_rst_lat1", o_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        check("post_rst_lat2", o_valid, 1'b1);
        check("post_rst_data", o_data, splat(32'd77));
        step();
        drain();

        // randomized traffic with random backpressure
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        exp_err = 1'b0;
        rdy_mode = 2;
        for (int i = 0; i < 80; i++) begin
            int r;
            logic [7:0] m;
            r = int'($urandom_range(0, 13));
            m = (r <= 11) ? 8'(r % 6) : 8'(8'h80 + r);
            for (int k = 0; k < NW; k++) d[k*WW +: WW] = pick();
            send(m, pick(), d);
        end
        drain();
        rdy_mode = 0;
        step();
        @(negedge clk);
        check("rand_count", o_beat_count, n_out);
        check("rand_err", o_mode_err, exp_err);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
